lfsr_crc_check: RTL and testbench
=================================

# lfsr_crc_check

Receive-side CRC checker, pairing with the CRC generator on the transmit side. It accepts a byte stream whose last LFSR_WIDTH/8 bytes are the transmitted CRC. It strips those bytes, forwards the payload with a corrected end-of-frame marker, and reports pass/fail per frame by comparing the final LFSR state against the polynomial residue. It sits directly behind the byte-wide receive framer, for example the Ethernet FCS check.

## Interface
- LFSR_WIDTH, 32, CRC width; must be a multiple of 8; N = LFSR_WIDTH/8 trailer bytes.
- LFSR_POLY, 32'h04c11db7, polynomial with the top term suppressed.
- LFSR_INIT, all ones, CRC state loaded at reset and at every frame start.
- LFSR_CONFIG, "GALOIS", passed to the `lfsr` core.
- REVERSE, 1, bit-reversed (LSB-first) operation, passed to the `lfsr` core.
- LFSR_RESIDUE, 32'hdebb20e3, un-inverted state expected after payload plus a good CRC.
- STYLE, "AUTO", passed to the `lfsr` core.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  received byte.
- data_in_valid  input  1  byte strobe; no backpressure.
- data_in_last  input  1  marks the final byte of a frame (the last CRC byte); qualified by data_in_valid.
- data_out  output  8  payload byte.
- data_out_valid  output  1  payload strobe.
- data_out_last  output  1  marks the final payload byte.
- status_valid  output  1  one-cycle pulse per frame.
- status_good  output  1  CRC matched and frame not runt; qualified by status_valid.
- status_runt  output  1  frame length ≤ N bytes; qualified by status_valid.

## Operation
- Uses one `lfsr` core instance, DATA_WIDTH = 8, fed by data_in and state_reg.
- On each valid beat, state_reg takes the core's next state.
  - If data_in_last = 1, state_reg reloads LFSR_INIT instead.
  - The compare uses the core's next state for that beat, before the reload.
- Trailer buffer: N-entry byte shift register plus fill counter (0..N, saturating).
- Valid beat with fill < N:
  - push the byte; fill increments;
  - no output.
- Valid beat with fill = N:
  - emit the oldest entry on data_out;
  - data_out_last = data_in_last;
  - shift the buffer and push the new byte.
- Trailer accounting on a last beat:
  - at fill = N, the remaining N−1 buffered entries plus the incoming byte form the CRC;
  - those entries are discarded;
  - fill clears to 0.
- Status on a last beat:
  - status_good = (next state == LFSR_RESIDUE) and frame length > N;
  - status_runt = frame length ≤ N, i.e. fill < N at the last beat, counting the last byte;
  - a runt emits no payload beats; status_good = 0.
- Frames of exactly N+1 bytes emit one payload byte, with data_out_last = 1.
- Back-to-back frames: the beat after a last beat starts a new frame from LFSR_INIT with an empty buffer. There are no gap requirements.

## Timing
- All outputs are registered.
- Reset values:
  - data_out = 0, data_out_valid = 0, data_out_last = 0;
  - status_valid = 0, status_good = 0, status_runt = 0;
  - fill = 0, state_reg = LFSR_INIT.
- Latency:
  - data_out_valid follows the causing input beat by exactly 1 cycle;
  - status_valid follows the last input beat by 1 cycle, in the same cycle as data_out_last when payload exists.
- data_out_valid and status_valid deassert in every cycle without a causing event.
- data_out and status_good hold their values between strobes.
- Reset mid-frame discards the buffer and the partial CRC, and emits no status for the aborted frame.
- Full throughput: a beat is accepted every cycle.

## Configuration
- Macro: LFSR_CRC_CHECK_STATS_EN.
- Defined:
  - adds outputs stat_good_count [15:0] and stat_bad_count [15:0];
  - each is incremented in the cycle status_valid is asserted, for good frames or for bad/runt frames respectively;
  - both saturate at 16'hffff and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Good frame:
  - stimulus: bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, last on CB, default parameters;
  - response: 9 output beats 31..39, last on 39; next-cycle status_valid = 1, status_good = 1, status_runt = 0.
- Corrupt frame:
  - stimulus: same frame with byte 35 changed to 34;
  - response: 9 beats, status_good = 0, status_runt = 0.
- Runt and boundary:
  - 3-byte frame AA BB CC (last) → no output beats; status_runt = 1, status_good = 0;
  - 5-byte frame → exactly one beat, with data_out_last = 1.
- Back-to-back:
  - stimulus: the good frame followed immediately by the corrupt frame, no idle cycles;
  - response: 18 payload beats; two status pulses, good then bad; the second frame's CRC starts from LFSR_INIT.
- Reset mid-frame:
  - stimulus: rst asserted after 6 bytes, then the good frame sent;
  - response: no output for the aborted bytes; good frame result is status_good = 1.
- With LFSR_CRC_CHECK_STATS_EN:
  - stimulus: 2 good frames and 1 runt;
  - response: stat_good_count = 2, stat_bad_count = 1;
  - counter preloaded near saturation holds at FFFF.

Source files
------------

// File: rtl/lfsr_crc_check_if.sv
// Byte-stream bundle between the receive framer, the CRC checker and the
// payload consumer.
//   data_in / data_in_valid / data_in_last : received bytes, last = final CRC byte
//   data_out / data_out_valid / data_out_last : payload with CRC trailer stripped
//   status_valid / status_good / status_runt  : per-frame verdict pulse
// master : the side feeding bytes and observing results (framer / bench)
// slave  : the checker
interface lfsr_crc_check_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_last;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_last;
    logic       status_valid;
    logic       status_good;
    logic       status_runt;

    modport master (
        output data_in, data_in_valid, data_in_last,
        input  data_out, data_out_valid, data_out_last,
        input  status_valid, status_good, status_runt
    );

    modport slave (
        input  data_in, data_in_valid, data_in_last,
        output data_out, data_out_valid, data_out_last,
        output status_valid, status_good, status_runt
    );
endinterface

// File: rtl/lfsr_crc_check.sv
// Receive-side CRC checker. Runs every received byte (payload and CRC
// trailer) through a byte-wide LFSR, holds back the last N = LFSR_WIDTH/8
// bytes so the trailer never reaches the payload output, and on the final
// byte reports good/runt by comparing the LFSR state with the residue.
//
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : lfsr_crc_check_if.slave (byte input, payload output, status)
//   stat_good_count, stat_bad_count : saturating frame counters, present
//                                     only when LFSR_CRC_CHECK_STATS_EN is defined
//
// Optional feature macro: LFSR_CRC_CHECK_STATS_EN

// Byte-parallel LFSR next-state core. Galois form; REVERSE selects the
// LSB-first (reflected) bit order used by Ethernet. The unrolled loop is the
// same logic for every STYLE value.
module lfsr #(
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
    parameter string                 LFSR_CONFIG = "GALOIS",
    parameter int                    REVERSE     = 1,
    parameter int                    DATA_WIDTH  = 8,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);
    if (LFSR_CONFIG != "GALOIS") begin : g_bad_config
        $error("lfsr: only the GALOIS configuration is implemented");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
        $error("lfsr: unknown STYLE");
    end

    function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
        for (int i = 0; i < LFSR_WIDTH; i++) bit_rev[i] = v[LFSR_WIDTH-1-i];
    endfunction

    localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

    always_comb begin : p_step
        logic [LFSR_WIDTH-1:0] s;
        logic                  fb;
        s = state_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE != 0) begin
                fb = s[0] ^ data_in[i];
                s  = (s >> 1) ^ (fb ? POLY_REV : '0);
            end else begin
                fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
                s  = (s << 1) ^ (fb ? LFSR_POLY : '0);
            end
        end
        state_out = s;
    end
endmodule

module lfsr_crc_check #(
    parameter int                    LFSR_WIDTH   = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 32'h04c11db7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = '1,
    parameter string                 LFSR_CONFIG  = "GALOIS",
    parameter int                    REVERSE      = 1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_RESIDUE = 32'hdebb20e3,
    parameter string                 STYLE        = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_crc_check_if.slave       bus
`ifdef LFSR_CRC_CHECK_STATS_EN
    ,
    output logic [15:0]           stat_good_count,
    output logic [15:0]           stat_bad_count
`endif
);
    localparam int N  = LFSR_WIDTH / 8;
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    if (LFSR_WIDTH % 8 != 0 || LFSR_WIDTH == 0) begin : g_bad_width
        $error("lfsr_crc_check: LFSR_WIDTH must be a non-zero multiple of 8");
    end

    logic [LFSR_WIDTH-1:0] state_reg;
    logic [LFSR_WIDTH-1:0] state_next;
    logic [N-1:0][7:0]     trailer;    // [0] newest, [N-1] oldest
    logic [FW-1:0]         fill;
    logic                  frame_good;

    lfsr #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .LFSR_POLY  (LFSR_POLY),
        .LFSR_CONFIG(LFSR_CONFIG),
        .REVERSE    (REVERSE),
        .DATA_WIDTH (8),
        .STYLE      (STYLE)
    ) u_lfsr (
        .data_in  (bus.data_in),
        .state_in (state_reg),
        .state_out(state_next)
    );

    // A frame whose last beat arrives with fewer than N bytes buffered is too
    // short to carry payload; the residue test only counts otherwise.
    assign frame_good = (fill == FULL) && (state_next == LFSR_RESIDUE);

    // Trailer contents need no reset: fill alone says which entries are live.
    always_ff @(posedge clk) begin
        if (bus.data_in_valid) begin
            trailer[0] <= bus.data_in;
            for (int i = 1; i < N; i++) trailer[i] <= trailer[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= LFSR_INIT;
            fill               <= '0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.data_out_last  <= 1'b0;
            bus.status_valid   <= 1'b0;
            bus.status_good    <= 1'b0;
            bus.status_runt    <= 1'b0;
        end else begin
            bus.data_out_valid <= 1'b0;
            bus.data_out_last  <= 1'b0;
            bus.status_valid   <= 1'b0;
            if (bus.data_in_valid) begin
                // Once N bytes are held, every new byte pushes the oldest out
                // as payload; the N held at the last beat are the CRC.
                if (fill == FULL) begin
                    bus.data_out       <= trailer[N-1];
                    bus.data_out_valid <= 1'b1;
                    bus.data_out_last  <= bus.data_in_last;
                end else begin
                    fill <= fill + 1'b1;
                end
                if (bus.data_in_last) begin
                    state_reg        <= LFSR_INIT;
                    fill             <= '0;
                    bus.status_valid <= 1'b1;
                    bus.status_good  <= frame_good;
                    bus.status_runt  <= (fill != FULL);
                end else begin
                    state_reg <= state_next;
                end
            end
        end
    end

`ifdef LFSR_CRC_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_good_count <= '0;
            stat_bad_count  <= '0;
        end else if (bus.data_in_valid && bus.data_in_last) begin
            if (frame_good) begin
                if (stat_good_count != 16'hffff) stat_good_count <= stat_good_count + 16'd1;
            end else begin
                if (stat_bad_count != 16'hffff) stat_bad_count <= stat_bad_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_lfsr_crc_check.sv
// Bench for lfsr_crc_check with default (Ethernet CRC-32) parameters.
// The reference model keeps the current frame as a byte queue: payload byte k
// leaves when byte k+N arrives, and a frame is good when it is longer than N
// and its last N bytes equal the complemented CRC-32 of the payload, LSB first.
module tb_lfsr_crc_check;
    localparam int NB = 4;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lfsr_crc_check_if bus();

`ifdef LFSR_CRC_CHECK_STATS_EN
    logic [15:0] stat_good_count, stat_bad_count;
`endif

    lfsr_crc_check dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LFSR_CRC_CHECK_STATS_EN
        ,
        .stat_good_count(stat_good_count),
        .stat_bad_count (stat_bad_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mframe[$];
    logic [7:0] e_dout;
    logic       e_dv, e_dl, e_sv, e_sg, e_sr;

    function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
        logic [31:0] c = 32'hffffffff;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic fcs_ok(input logic [7:0] q[$]);
        int p = q.size() - NB;
        logic [31:0] c = crc32(q, p);
        for (int k = 0; k < NB; k++) if (q[p+k] !== c[8*k +: 8]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bq_t with_fcs(input logic [7:0] p[$]);
        bq_t f = p;
        logic [31:0] c = crc32(p, p.size());
        for (int k = 0; k < NB; k++) f.push_back(c[8*k +: 8]);
        return f;
    endfunction

    function automatic void model_reset();
        mframe.delete();
        e_dout = '0; e_dv = 0; e_dl = 0; e_sv = 0; e_sg = 0; e_sr = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] b, input logic l);
        e_dv = 0; e_dl = 0; e_sv = 0;
        if (v) begin
            mframe.push_back(b);
            if (mframe.size() > NB) begin
                e_dout = mframe[mframe.size() - 1 - NB];
                e_dv   = 1;
                e_dl   = l;
            end
            if (l) begin
                e_sv = 1;
                e_sr = (mframe.size() <= NB);
                e_sg = !e_sr && fcs_ok(mframe);
                mframe.delete();
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_dout, e_dv, e_dl, e_sv, e_sg, e_sr};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.data_out, bus.data_out_valid, bus.data_out_last,
                bus.status_valid, bus.status_good, bus.status_runt};
    endfunction

    // One input cycle, applied to DUT and model alike; outputs are read #1
    // after the edge that consumed the beat.
    task automatic beat(input logic v, input logic [7:0] b, input logic l);
        bus.data_in = b; bus.data_in_valid = v; bus.data_in_last = l;
        @(posedge clk); #1;
        bus.data_in_valid = 0; bus.data_in_last = 0;
        model_step(v, b, l);
    endtask

    function automatic bq_t good_frame();
        bq_t f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hf4, 8'hcb};
        return f;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; bus.data_in = '0; bus.data_in_valid = 0; bus.data_in_last = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", obs_vec(), 13'h0);
        end
        rst = 0;
    endtask

    task automatic test_good_frame();
        bq_t f = good_frame();
        int  nout = 0;
        foreach (f[i]) begin
            beat(1, f[i], i == f.size() - 1);
            if (bus.data_out_valid) nout++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL good_frame beat %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({bus.data_out, bus.data_out_last, bus.status_valid, bus.status_good, bus.status_runt} !== {8'h39, 4'b1110}) begin
            failures++;
            $display("FAIL good_frame_status: got %h/%b%b%b%b want 39/1110", bus.data_out,
                     bus.data_out_last, bus.status_valid, bus.status_good, bus.status_runt);
        end
        checks++;
        if (nout !== 9) begin
            failures++;
            $display("FAIL good_frame_beats: got %0d want 9", nout);
        end
        beat(0, 8'h00, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL good_frame_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_corrupt_frame();
        bq_t f = good_frame();
        int  nout = 0;
        f[4] = 8'h34;
        foreach (f[i]) begin
            beat(1, f[i], i == f.size() - 1);
            if (bus.data_out_valid) nout++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL corrupt_frame beat %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({nout[3:0], bus.status_valid, bus.status_good, bus.status_runt} !== {4'd9, 3'b100}) begin
            failures++;
            $display("FAIL corrupt_frame_status: got beats=%0d sv/sg/sr=%b%b%b want 9/100", nout,
                     bus.status_valid, bus.status_good, bus.status_runt);
        end
    endtask

    task automatic test_runt_boundary();
        bq_t fr[4];
        bq_t p  = '{8'h5a};
        int  nout;
        fr[0] = '{8'haa, 8'hbb, 8'hcc};
        fr[1] = with_fcs(p);                     // N+1 bytes, one payload byte
        fr[2] = '{8'h11, 8'h22, 8'h33, 8'h44};   // exactly N: still a runt
        fr[3] = '{8'h77};
        for (int n = 0; n < 4; n++) begin
            nout = 0;
            foreach (fr[n][i]) begin
                beat(1, fr[n][i], i == fr[n].size() - 1);
                if (bus.data_out_valid) nout++;
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL runt_boundary frame %0d beat %0d: got %h want %h", n, i, obs_vec(), exp_vec());
                end
            end
            checks++;
            if (n == 1) begin
                if ({nout[1:0], bus.data_out, bus.data_out_last, bus.status_good, bus.status_runt} !== {2'd1, 8'h5a, 3'b110}) begin
                    failures++;
                    $display("FAIL boundary_n_plus_1: got beats=%0d data=%h last/sg/sr=%b%b%b want 1/5a/110",
                             nout, bus.data_out, bus.data_out_last, bus.status_good, bus.status_runt);
                end
            end else begin
                if ({nout[1:0], bus.status_valid, bus.status_good, bus.status_runt} !== {2'd0, 3'b101}) begin
                    failures++;
                    $display("FAIL runt frame %0d: got beats=%0d sv/sg/sr=%b%b%b want 0/101", n, nout,
                             bus.status_valid, bus.status_good, bus.status_runt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t g = good_frame();
        bq_t b = good_frame();
        bq_t f;
        int  nout = 0;
        logic [1:0] verdicts = '0;
        int  nstat = 0;
        b[4] = 8'h34;
        f = g;
        foreach (b[i]) f.push_back(b[i]);
        foreach (f[i]) begin
            beat(1, f[i], (i == 12) || (i == 25));
            if (bus.data_out_valid) nout++;
            if (bus.status_valid) begin
                verdicts = {verdicts[0], bus.status_good};
                nstat++;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back beat %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (nout !== 18 || nstat !== 2 || verdicts !== 2'b10) begin
            failures++;
            $display("FAIL back_to_back_summary: got beats=%0d pulses=%0d verdicts=%b want 18/2/10",
                     nout, nstat, verdicts);
        end
    endtask

    task automatic test_reset_mid_frame();
        bq_t g = good_frame();
        for (int i = 0; i < 6; i++) begin
            beat(1, g[i], 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_frame pre beat %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        checks++;
        if (obs_vec() !== 13'h0) begin
            failures++;
            $display("FAIL reset_mid_frame_clear: got %h want %h", obs_vec(), 13'h0);
        end
        foreach (g[i]) begin
            beat(1, g[i], i == g.size() - 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_mid_frame beat %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({bus.status_valid, bus.status_good} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_frame_status: got sv/sg=%b%b want 11", bus.status_valid, bus.status_good);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bq_t p;
            bq_t f;
            int  plen = $urandom_range(0, 12);
            for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
            f = with_fcs(p);
            case ($urandom_range(0, 3))
                0: f[$urandom_range(0, f.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
                1: while (f.size() > 1 && $urandom_range(0, 1) == 1) void'(f.pop_back());
                default: ;
            endcase
            foreach (f[i]) begin
                // Idle cycles carry junk data and a stray last flag.
                while ($urandom_range(0, 3) == 0) begin
                    beat(0, 8'($urandom), 1'($urandom));
                    checks++;
                    if (obs_vec() !== exp_vec()) begin
                        failures++;
                        $display("FAIL random frame %0d idle: got %h want %h", n, obs_vec(), exp_vec());
                    end
                end
                beat(1, f[i], i == f.size() - 1);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random frame %0d beat %0d: got %h want %h", n, i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

`ifdef LFSR_CRC_CHECK_STATS_EN
    task automatic test_stats();
        bq_t g = good_frame();
        bq_t r = '{8'haa, 8'hbb, 8'hcc};
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        for (int k = 0; k < 2; k++) foreach (g[i]) beat(1, g[i], i == g.size() - 1);
        foreach (r[i]) beat(1, r[i], i == r.size() - 1);
        checks++;
        if (stat_good_count !== 16'd2 || stat_bad_count !== 16'd1) begin
            failures++;
            $display("FAIL stats_counts: got good=%0d bad=%0d want 2/1", stat_good_count, stat_bad_count);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_corrupt_frame();
        test_runt_boundary();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef LFSR_CRC_CHECK_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
